// File: rtl/cdc_in_serializer.sv
// -----------------------------------------------------------------------------
// cdc_in_serializer
//
// Purpose:
//   Accepts 32-bit words from the CPU core into a small word FIFO. A serializer
//   then sends each word into the USB CDC IN byte stream, least significant byte
//   first, and only bytes 0..size of each word. The CPU therefore never waits on
//   the per-byte USB handshake.
//
// Optional build macro: PAKO32_TX_HEX_EN
//   When this macro is defined, every payload byte goes out as two uppercase
//   ASCII hex characters, high nibble first. Each character has its own
//   handshake. When it is not defined, raw bytes go out and no hex logic is
//   built.
//
// Ports:
//   clk_i       in   1        application clock, rising edge
//   rst_i       in   1        synchronous active-high reset
//   wr_data_i   in   32       word to transmit, byte 0 = bits [7:0]
//   wr_size_i   in   2        number of bytes to send minus one
//   wr_valid_i  in   1        write request
//   wr_ready_o  out  1        FIFO can accept a word
//   in_data_o   out  8        byte/character to the usb_cdc IN endpoint
//   in_valid_o  out  1        in_data_o valid
//   in_ready_i  in   1        usb_cdc accepts the byte
//   level_o     out  LEVEL_W  FIFO occupancy in words (serializer word excluded)
//   empty_o     out  1        FIFO empty and serializer idle
// -----------------------------------------------------------------------------
module cdc_in_serializer #(
  parameter int DEPTH   = 8,
  parameter int LEVEL_W = $clog2(DEPTH) + 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [31:0]        wr_data_i,
  input  logic [1:0]         wr_size_i,
  input  logic               wr_valid_i,
  output logic               wr_ready_o,
  output logic [7:0]         in_data_o,
  output logic               in_valid_o,
  input  logic               in_ready_i,
  output logic [LEVEL_W-1:0] level_o,
  output logic               empty_o
);

  localparam int AW = $clog2(DEPTH);

`ifdef PAKO32_TX_HEX_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SEND_HI = 2'd1, ST_SEND_LO = 2'd2} state_t;

  // Maps a nibble to its uppercase ASCII hex character.
  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    logic [7:0] ch;
    if (nib < 4'd10) begin
      ch = 8'h30 + {4'h0, nib};
    end else begin
      ch = 8'h37 + {4'h0, nib};
    end
    return ch;
  endfunction
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SEND = 2'd1} state_t;
`endif

  logic [33:0]        mem_r [DEPTH];
  logic [AW-1:0]      wr_ptr_r;
  logic [AW-1:0]      rd_ptr_r;
  logic [LEVEL_W-1:0] level_r;
  logic [LEVEL_W-1:0] level_next_s;
  logic               wr_ready_r;
  logic               push_s;
  logic               pop_s;
  logic               fifo_nempty_s;
  logic [33:0]        head_s;

  state_t             state_r;
  logic [23:0]        shift_r;      // payload bytes that remain after the current one
  logic [1:0]         cnt_r;        // number of bytes that remain after the current one
  logic [7:0]         in_data_r;
  logic               in_valid_r;
`ifdef PAKO32_TX_HEX_EN
  logic [7:0]         cur_byte_r;   // byte whose two characters are being sent
`endif

  assign head_s        = mem_r[rd_ptr_r];
  assign fifo_nempty_s = (level_r != {LEVEL_W{1'b0}});
  assign push_s        = wr_valid_i && wr_ready_r;
  assign level_next_s  = level_r + LEVEL_W'(push_s) - LEVEL_W'(pop_s);

  // Decides whether the serializer takes the FIFO head on this edge.
  always_comb begin
    pop_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        pop_s = fifo_nempty_s;
      end
`ifdef PAKO32_TX_HEX_EN
      ST_SEND_LO: begin
        pop_s = in_ready_i && (cnt_r == 2'd0) && fifo_nempty_s;
      end
`else
      ST_SEND: begin
        pop_s = in_ready_i && (cnt_r == 2'd0) && fifo_nempty_s;
      end
`endif
      default: begin
        pop_s = 1'b0;
      end
    endcase
  end

  // Word storage. It has no reset because the pointers define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {wr_size_i, wr_data_i};
    end
  end

  // FIFO pointers, occupancy and registered ready. The ready flag depends only
  // on the new level, so a full FIFO cannot accept a word even when a pop
  // happens in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      level_r    <= {LEVEL_W{1'b0}};
      wr_ready_r <= 1'b1;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      level_r    <= level_next_s;
      wr_ready_r <= (level_next_s != LEVEL_W'(DEPTH));
    end
  end

  // Serializer FSM with registered IN-side outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r    <= ST_IDLE;
      shift_r    <= 24'h000000;
      cnt_r      <= 2'd0;
      in_data_r  <= 8'h00;
      in_valid_r <= 1'b0;
`ifdef PAKO32_TX_HEX_EN
      cur_byte_r <= 8'h00;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            shift_r    <= head_s[31:8];
            cnt_r      <= head_s[33:32];
            in_valid_r <= 1'b1;
`ifdef PAKO32_TX_HEX_EN
            cur_byte_r <= head_s[7:0];
            in_data_r  <= hex_char(head_s[7:4]);
            state_r    <= ST_SEND_HI;
`else
            in_data_r  <= head_s[7:0];
            state_r    <= ST_SEND;
`endif
          end
        end
`ifdef PAKO32_TX_HEX_EN
        ST_SEND_HI: begin
          if (in_ready_i) begin
            in_data_r <= hex_char(cur_byte_r[3:0]);
            state_r   <= ST_SEND_LO;
          end
        end
        ST_SEND_LO: begin
          if (in_ready_i) begin
            if (cnt_r != 2'd0) begin
              cur_byte_r <= shift_r[7:0];
              in_data_r  <= hex_char(shift_r[7:4]);
              shift_r    <= {8'h00, shift_r[23:8]};
              cnt_r      <= cnt_r - 2'd1;
              state_r    <= ST_SEND_HI;
            end else if (pop_s) begin
              // Back-to-back words: the next word's first character follows without a gap.
              cur_byte_r <= head_s[7:0];
              in_data_r  <= hex_char(head_s[7:4]);
              shift_r    <= head_s[31:8];
              cnt_r      <= head_s[33:32];
              state_r    <= ST_SEND_HI;
            end else begin
              in_valid_r <= 1'b0;
              state_r    <= ST_IDLE;
            end
          end
        end
`else
        ST_SEND: begin
          if (in_ready_i) begin
            if (cnt_r != 2'd0) begin
              in_data_r <= shift_r[7:0];
              shift_r   <= {8'h00, shift_r[23:8]};
              cnt_r     <= cnt_r - 2'd1;
            end else if (pop_s) begin
              // Back-to-back words: the next word's byte 0 follows without a gap.
              in_data_r <= head_s[7:0];
              shift_r   <= head_s[31:8];
              cnt_r     <= head_s[33:32];
            end else begin
              in_valid_r <= 1'b0;
              state_r    <= ST_IDLE;
            end
          end
        end
`endif
        default: begin
          state_r    <= ST_IDLE;
          in_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign wr_ready_o = wr_ready_r;
  assign in_data_o  = in_data_r;
  assign in_valid_o = in_valid_r;
  assign level_o    = level_r;
  // This output is derived only from registers, so it has no combinational input path.
  assign empty_o    = (level_r == {LEVEL_W{1'b0}}) && (state_r == ST_IDLE);

endmodule

// File: tb/tb_cdc_in_serializer.sv
// -----------------------------------------------------------------------------
// tb_cdc_in_serializer
//
// Drives directed and random traffic into cdc_in_serializer. An abstract model
// predicts the outputs. It keeps a queue of words waiting in the FIFO and a
// queue of the bytes/characters of the word that is being sent.
// -----------------------------------------------------------------------------
module tb_cdc_in_serializer;

  localparam int DEPTH   = 8;
  localparam int LEVEL_W = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [31:0]        wr_data;
  logic [1:0]         wr_size;
  logic               wr_valid;
  logic               wr_ready;
  logic [7:0]         in_data;
  logic               in_valid;
  logic               in_ready;
  logic [LEVEL_W-1:0] level;
  logic               empty;

  always #5 clk = ~clk;

  cdc_in_serializer #(.DEPTH(DEPTH), .LEVEL_W(LEVEL_W)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .wr_data_i  (wr_data),
    .wr_size_i  (wr_size),
    .wr_valid_i (wr_valid),
    .wr_ready_o (wr_ready),
    .in_data_o  (in_data),
    .in_valid_o (in_valid),
    .in_ready_i (in_ready),
    .level_o    (level),
    .empty_o    (empty)
  );

  int checks = 0;
  int errors = 0;

  logic [33:0] m_fifo [$];   // words waiting in the FIFO
  logic [7:0]  m_out  [$];   // remaining symbols of the word being sent; head = presented
  bit          last_accept = 1'b0;
  bit          chk_en = 1'b0;
  int          exp_syms = 0;
  int          dut_syms = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    if (n < 4'd10) return 8'd48 + 8'(n);
    else return 8'd65 + 8'(n) - 8'd10;
  endfunction

  // Adds the symbols of one word to the output queue.
  task automatic load_word(input logic [33:0] e);
    logic [31:0] d;
    logic [7:0]  b;
    int nb;
    d  = e[31:0];
    nb = int'(e[33:32]) + 1;
    for (int i = 0; i < nb; i++) begin
      b = d[8*i +: 8];
`ifdef PAKO32_TX_HEX_EN
      m_out.push_back(hexc(b[7:4]));
      m_out.push_back(hexc(b[3:0]));
`else
      m_out.push_back(b);
`endif
    end
  endtask

  // Reference model, updated once per rising edge.
  initial begin
    bit acc, hs, need;
    logic [33:0] e;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_fifo.delete();
        m_out.delete();
        last_accept = 1'b0;
      end else begin
        acc  = wr_valid && (m_fifo.size() != DEPTH);
        hs   = (m_out.size() != 0) && in_ready;
        need = (m_out.size() == 0) || (hs && m_out.size() == 1);
        if (hs) void'(m_out.pop_front());
        if (need && m_fifo.size() != 0) begin
          e = m_fifo.pop_front();
          load_word(e);
        end
        if (acc) begin
          m_fifo.push_back({wr_size, wr_data});
`ifdef PAKO32_TX_HEX_EN
          exp_syms += 2 * (int'(wr_size) + 1);
`else
          exp_syms += int'(wr_size) + 1;
`endif
        end
        last_accept = acc;
      end
    end
  end

  // Compares the DUT against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en && !rst) begin
        chk("in_valid", in_valid, (m_out.size() != 0));
        if (m_out.size() != 0) chk("in_data", in_data, m_out[0]);
        chk("level", level, m_fifo.size());
        chk("wr_ready", wr_ready, (m_fifo.size() != DEPTH));
        chk("empty", empty, (m_fifo.size() == 0 && m_out.size() == 0));
        if (in_valid && in_ready) dut_syms++;
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] d, input logic [1:0] s);
    bit got;
    got = 1'b0;
    wr_data  = d;
    wr_size  = s;
    wr_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      step();
      if (last_accept) begin
        got = 1'b1;
        break;
      end
    end
    wr_valid = 1'b0;
    chk("push_accept", got, 1'b1);
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (m_fifo.size() == 0 && m_out.size() == 0) begin
        done = 1'b1;
        break;
      end
      step();
    end
    chk("drain_timeout", done, 1'b1);
  endtask

  initial begin
    rst = 1'b1; wr_data = 32'h0; wr_size = 2'd0; wr_valid = 1'b0; in_ready = 1'b0;
    step();
    step();
    chk("rst_wr_ready", wr_ready, 1'b1);
    chk("rst_in_valid", in_valid, 1'b0);
    chk("rst_in_data", in_data, 8'h00);
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1'b1);
    rst = 1'b0;
    chk_en = 1'b1;
    step();

`ifndef PAKO32_TX_HEX_EN
    // Four bytes in consecutive cycles, first byte one cycle after the write.
    in_ready = 1'b1;
    wr_data = 32'h44332211; wr_size = 2'd3; wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
    chk("t1_not_yet", in_valid, 1'b0);
    step(); chk("t1_v0", in_valid, 1'b1); chk("t1_b0", in_data, 8'h11);
    step(); chk("t1_b1", in_data, 8'h22);
    step(); chk("t1_b2", in_data, 8'h33);
    step(); chk("t1_b3", in_data, 8'h44);
    step(); chk("t1_done", in_valid, 1'b0); chk("t1_empty", empty, 1'b1);

    // Back-pressure.
    in_ready = 1'b0;
    wr_data = 32'h0000BEEF; wr_size = 2'd1; wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_valid", in_valid, 1'b1);
      chk("bp_hold_data", in_data, 8'hEF);
    end
    in_ready = 1'b1;
    step(); chk("bp_b1", in_data, 8'hBE); chk("bp_v1", in_valid, 1'b1);
    step(); chk("bp_end", in_valid, 1'b0);

    // Full FIFO.
    in_ready = 1'b0;
    for (int i = 0; i <= DEPTH; i++) push_word(32'h10 + 32'(i), 2'd0);
    chk("full_level", level, 8);
    chk("full_ready", wr_ready, 1'b0);
    chk("full_head", in_data, 8'h10);
    wr_data = 32'h99; wr_size = 2'd0; wr_valid = 1'b1;
    step(); step(); step();
    chk("full_reject_level", level, 8);
    wr_valid = 1'b0;
    in_ready = 1'b1;
    wait_idle(100);
    chk("full_drained", empty, 1'b1);

    // A push and a pop in the same cycle at level 3.
    in_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(32'h21 + 32'(i), 2'd0);
    chk("sim_level_pre", level, 3);
    wr_data = 32'h25; wr_size = 2'd0; wr_valid = 1'b1; in_ready = 1'b1;
    step();
    wr_valid = 1'b0;
    chk("sim_level_post", level, 3);
    chk("sim_next", in_data, 8'h22);
    wait_idle(100);

    // Reset in the middle of a word.
    in_ready = 1'b1;
    push_word(32'h04030201, 2'd3);
    push_word(32'h0B0A0908, 2'd3);
    chk("mid_b0", in_data, 8'h01);
    step(); step();
    chk("mid_b2", in_data, 8'h03);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", in_valid, 1'b0);
    chk("mid_rst_level", level, 0);
    push_word(32'h000000A5, 2'd0);
    chk("mid_a5_lat", in_valid, 1'b0);
    step(); chk("mid_a5_v", in_valid, 1'b1); chk("mid_a5", in_data, 8'hA5);
    step(); chk("mid_a5_end", in_valid, 1'b0); chk("mid_a5_empty", empty, 1'b1);
`else
    // Hex mode: "A5" then "5A".
    in_ready = 1'b1;
    push_word(32'h00005AA5, 2'd1);
    chk("hex_lat", in_valid, 1'b0);
    step(); chk("hex_c0", in_data, 8'h41);
    step(); chk("hex_c1", in_data, 8'h35);
    step(); chk("hex_c2", in_data, 8'h35);
    step(); chk("hex_c3", in_data, 8'h41);
    step(); chk("hex_end", in_valid, 1'b0);
`endif

    // Random traffic with symbol-count scoreboard.
    wait_idle(200);
    exp_syms = 0;
    dut_syms = 0;
    for (int i = 0; i < 500; i++) begin
      wr_valid = ($urandom_range(0, 9) < 7);
      wr_data  = $urandom;
      wr_size  = 2'($urandom_range(0, 3));
      in_ready = (i % 100 < 40) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8);
      step();
    end
    wr_valid = 1'b0;
    in_ready = 1'b1;
    wait_idle(400);
    step();
    chk("rand_sym_count", dut_syms, exp_syms);
    chk("rand_empty", empty, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdc_in_serializer.md
Name: cdc_in_serializer

Overview:
- Transmit-side companion to the CPU's byte-stream receive path: accepts 32-bit words from the CPU core and serializes them into the USB CDC IN byte stream.
- Contains a word FIFO and a byte serializer. The serializer drives the usb_cdc IN interface (in_data/in_valid/in_ready) in the app clock domain (clk_2mhz).
- Keeps the CPU from stalling on per-byte USB handshakes.

Parameters:
- DEPTH, 8, FIFO depth in words; power of 2, minimum 2.
- LEVEL_W, $clog2(DEPTH)+1, width of level_o.

Ports:
- clk_i  input  1  application clock; all logic on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- wr_data_i  input  32  word to transmit; byte 0 is bits [7:0].
- wr_size_i  input  2  number of bytes to send minus 1 (0 = 1 byte ... 3 = 4 bytes).
- wr_valid_i  input  1  write request.
- wr_ready_o  output  1  FIFO can accept a word.
- in_data_o  output  8  byte to usb_cdc IN endpoint.
- in_valid_o  output  1  in_data_o valid.
- in_ready_i  input  1  usb_cdc accepts byte.
- level_o  output  LEVEL_W  FIFO occupancy in words; excludes the word held in the serializer.
- empty_o  output  1  FIFO empty AND serializer idle (all data drained).

Behaviour:
- Reset: one clock; reset is synchronous and active-high (clk_i, rst_i).
  - Reset values: wr_ready_o=1, in_valid_o=0, in_data_o=0, level_o=0, empty_o=1.
  - FIFO pointers and FSM clear.
  - Reset mid-transfer discards the FIFO contents and any partially sent word; no further bytes are emitted.
- Write side:
  - A word+size is pushed when wr_valid_i && wr_ready_o.
  - wr_ready_o = (level_o != DEPTH), registered-equivalent. It is low when full, even if a pop occurs in the same cycle (no full-bypass).
- FIFO:
  - Entries are 34 bits {size, data}.
  - Read and write pointers are log2(DEPTH) bits and wrap naturally.
  - Push and pop in the same cycle leave level_o unchanged.
- Serializer FSM:
  - IDLE:
    - If the FIFO is non-empty, pop the head into a shift register and a byte counter (cnt = size).
    - Drive in_data_o = data[7:0] and in_valid_o = 1 at the next edge; go to SEND.
  - SEND:
    - While in_valid_o && !in_ready_i, hold in_data_o and in_valid_o stable.
    - On in_ready_i with cnt != 0: shift right 8, cnt--, present the next byte the following cycle with in_valid_o kept at 1.
    - On in_ready_i with cnt == 0, if the FIFO is non-empty: pop the next word and present its byte 0 on the next cycle (back-to-back, no bubble).
    - On in_ready_i with cnt == 0, if the FIFO is empty: in_valid_o=0, go to IDLE.
- Latency: a word written into an empty, idle block at edge N has in_valid_o=1 with byte 0 after edge N+1.
- Throughput: 1 byte/cycle when in_ready_i is held high.
- Byte order: little-endian, bytes 0..size only; upper bytes are never sent.
- in_valid_o never deasserts without a handshake, except on reset.
- empty_o = (level_o==0) && FSM==IDLE.

Optional Feature:
- Macro: PAKO32_TX_HEX_EN.
- With the macro defined, each payload byte is emitted as two uppercase ASCII hex characters, high nibble first ('0'-'9' = 0x30-0x39, 'A'-'F' = 0x41-0x46).
  - SEND splits into SEND_HI/SEND_LO; each character needs its own in_valid/in_ready handshake.
  - Bytes still go out in little-endian order.
  - Throughput is 2 characters per payload byte.
- Without the macro: raw bytes; the SEND_LO state and hex logic are not synthesized.

Test Plan:
- Reset, idle, in_ready_i=1:
  - write 0x44332211 size=3 -> in_data_o 0x11,0x22,0x33,0x44 on 4 consecutive cycles;
  - first valid 1 cycle after the write;
  - empty_o=1 after the last handshake.
- Back-pressure:
  - write 0x0000BEEF size=1 with in_ready_i=0 for 5 cycles -> in_data_o stays 0xEF, in_valid_o stays 1;
  - release -> 0xEF, then 0xBE, then in_valid_o=0.
- Full:
  - hold in_ready_i=0, write DEPTH+1 words -> first word moves to the serializer;
  - after DEPTH further accepted writes, level_o=8 and wr_ready_o=0;
  - the extra write is not accepted; data order is preserved on drain.
- Simultaneous: with level_o=3, push and pop in the same cycle -> level_o stays 3; no byte is lost or duplicated over 100 random words (scoreboard).
- Reset mid-word:
  - assert rst_i after 2 of 4 bytes -> next cycle in_valid_o=0, level_o=0;
  - a new word 0x000000A5 size=0 then sends 0xA5 only.
- PAKO32_TX_HEX_EN: write 0x00005AA5 size=1 -> characters 0x41,0x35,0x35,0x41 ("A5","5A").
